// File: rtl/cpu_clock_control.sv
`timescale 1ns/1ps
// CPU advance-enable generator: periodic cpu_en in run mode, one cpu_en per debounced
// step press in manual mode, plus a running count of issued enables.
module cpu_clock_control #(
   parameter int RUN_DIV         = 50,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int COUNT_W         = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               manual_mode,
   input  logic               step_btn,
   output logic               cpu_en,
   output logic               mode_led,
   output logic               step_led,
   output logic [COUNT_W-1:0] step_count
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DIV_W = $clog2(RUN_DIV);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MAN_IDLE = 2'd1,
      MAN_HELD = 2'd2
   } state_t;

   logic [1:0] raw_in;
   logic [1:0] db_vec;

   // Bit 0 = mode switch, bit 1 = step button; both take the same sync + debounce path.
   assign raw_in = {step_btn, manual_mode};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
         logic            sync1_reg;
         logic            sync2_reg;
         logic            stable_reg;
         logic [DB_W-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               sync1_reg  <= 1'b0;
               sync2_reg  <= 1'b0;
               stable_reg <= 1'b0;
               cnt_reg    <= '0;
            end else begin
               sync1_reg <= raw_in[gi];
               sync2_reg <= sync1_reg;
               if (sync2_reg == stable_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DB_LAST) begin
                  stable_reg <= ~stable_reg;
                  cnt_reg    <= '0;
               end else begin
                  cnt_reg <= cnt_reg + DB_W'(1);
               end
            end
         end

         assign db_vec[gi] = stable_reg;
      end
   endgenerate

   logic mode_db;
   logic step_db;
   logic step_prev_reg;
   logic step_rise;

   assign mode_db   = db_vec[0];
   assign step_db   = db_vec[1];
   // Edge-detected so a button already held when manual mode is entered does not step.
   assign step_rise = step_db & ~step_prev_reg;

   state_t             state_reg, state_next;
   logic [DIV_W-1:0]   div_reg, div_next;
   logic               cpu_en_reg, cpu_en_next;
   logic [COUNT_W-1:0] count_reg;

   always_comb begin
      state_next  = state_reg;
      div_next    = '0;
      cpu_en_next = 1'b0;
      case (state_reg)
         RUN: begin
            if (mode_db) begin
               state_next = MAN_IDLE;
            end else begin
               cpu_en_next = (div_reg == DIV_LAST);
               div_next    = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
            end
         end
         MAN_IDLE: begin
            if (!mode_db) begin
               state_next = RUN;
            end else if (step_rise) begin
               state_next  = MAN_HELD;
               cpu_en_next = 1'b1;
            end
         end
         MAN_HELD: begin
            // Leaving manual mode wins over a simultaneous release.
            if (!mode_db) begin
               state_next = RUN;
            end else if (!step_db) begin
               state_next = MAN_IDLE;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= RUN;
         div_reg       <= '0;
         cpu_en_reg    <= 1'b0;
         count_reg     <= '0;
         step_prev_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         div_reg       <= div_next;
         cpu_en_reg    <= cpu_en_next;
         count_reg     <= count_reg + COUNT_W'(cpu_en_reg);
         step_prev_reg <= step_db;
      end
   end

   assign cpu_en     = cpu_en_reg;
   assign mode_led   = mode_db;
   assign step_led   = step_db;
   assign step_count = count_reg;

endmodule

// File: tb/tb_cpu_clock_control.sv
`timescale 1ns/1ps
// Bench for cpu_clock_control: expected pulse cycles go into a queue when stimulus is
// driven; a negedge monitor pops and compares every observed cpu_en pulse.
module tb_cpu_clock_control;

   localparam int RUN_DIV = 4;
   localparam int DEB     = 8;
   localparam int CW      = 16;
   localparam int LAT     = 2 + DEB + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          manual_mode;
   logic          step_btn;
   logic          cpu_en;
   logic          mode_led;
   logic          step_led;
   logic [CW-1:0] step_count;

   cpu_clock_control #(
      .RUN_DIV(RUN_DIV),
      .DEBOUNCE_CYCLES(DEB),
      .COUNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .manual_mode(manual_mode),
      .step_btn(step_btn),
      .cpu_en(cpu_en),
      .mode_led(mode_led),
      .step_led(step_led),
      .step_count(step_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Scoreboard consumer: every cpu_en pulse must match the oldest expected cycle.
   always @(negedge clk) begin
      int e;
      if (cpu_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, required no pulse", cyc);
         end else begin
            e = exp_q.pop_front();
            $display("pulse at cycle %0d (expected %0d) step_count=%0h", cyc, e, step_count);
            check("pulse_time", 32'(cyc), 32'(e));
         end
      end
   end

   task automatic tick_to(input int target);
      while (cyc < target) @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int press;
      int rel;
      int exp_pulses;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int r, c0, c1, p, model_cnt;

      vecs[0] = '{press: 3,   rel: 12, exp_pulses: 0};
      vecs[1] = '{press: 7,   rel: 12, exp_pulses: 0};
      vecs[2] = '{press: 8,   rel: 12, exp_pulses: 1};
      vecs[3] = '{press: 100, rel: 12, exp_pulses: 1};
      vecs[4] = '{press: 20,  rel: 12, exp_pulses: 1};

      reset       = 1'b1;
      manual_mode = 1'b1;
      step_btn    = 1'b1;

      // Reset held 3 clks with both raw inputs high.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst_cpu_en", 32'(cpu_en), 32'd0);
         check("rst_mode_led", 32'(mode_led), 32'd0);
         check("rst_step_led", 32'(step_led), 32'd0);
         check("rst_step_count", 32'(step_count), 32'd0);
      end
      reset    = 1'b0;
      step_btn = 1'b0;
      r        = cyc;
      // Run mode until the raw mode switch is debounced into manual.
      exp_q.push_back(r + RUN_DIV);
      exp_q.push_back(r + 2 * RUN_DIV);
      tick_to(r + 14);
      check("reset_run_pulses_pending", 32'(exp_q.size()), 32'd0);
      check("reset_mode_led", 32'(mode_led), 32'd1);
      check("reset_step_led", 32'(step_led), 32'd0);
      check("reset_step_count", 32'(step_count), 32'd2);
      model_cnt = 2;

      // Table of single presses in manual mode.
      for (int v = 0; v < 5; v++) begin
         c0       = cyc;
         step_btn = 1'b1;
         if (vecs[v].exp_pulses != 0) exp_q.push_back(c0 + LAT);
         ticks(vecs[v].press);
         step_btn = 1'b0;
         ticks(vecs[v].rel);
         model_cnt += vecs[v].exp_pulses;
         $display("press %0d clks -> step_count=%0d", vecs[v].press, step_count);
         check("press_pending", 32'(exp_q.size()), 32'd0);
         check("press_step_count", 32'(step_count), 32'(model_cnt));
      end

      // Bounce: toggle every 3 clks for 30 clks, then hold.
      for (int k = 0; k < 10; k++) begin
         step_btn = (k % 2 == 0);
         ticks(3);
      end
      step_btn = 1'b1;
      c1 = cyc;
      exp_q.push_back(c1 + LAT);
      ticks(20);
      model_cnt += 1;
      check("bounce_step_led", 32'(step_led), 32'd1);
      check("bounce_step_count", 32'(step_count), 32'(model_cnt));
      check("bounce_pending", 32'(exp_q.size()), 32'd0);
      step_btn = 1'b0;
      ticks(12);
      check("bounce_release_led", 32'(step_led), 32'd0);

      // Mode switch to run while the step button is held.
      step_btn = 1'b1;
      c0 = cyc;
      exp_q.push_back(c0 + LAT);
      ticks(14);
      model_cnt += 1;
      manual_mode = 1'b0;
      c1 = cyc;
      for (int k = 0; k < 10; k++) exp_q.push_back(c1 + 2 + DEB + 1 + RUN_DIV * (k + 1));
      ticks(12);
      check("switch_mode_led", 32'(mode_led), 32'd0);
      tick_to(c1 + 53);
      model_cnt += 10;
      check("run_pending", 32'(exp_q.size()), 32'd0);
      check("run_step_count", 32'(step_count), 32'(model_cnt));

      // Counter wrap via preloaded value.
      p = c1 + 55;
      for (int k = 0; k < 4; k++) exp_q.push_back(p + RUN_DIV * k);
      tick_to(p + 1);
      force dut.count_reg = 16'hFFFE;
      tick_to(p + 2);
      release dut.count_reg;
      tick_to(p + 5);
      check("wrap_ffff", 32'(step_count), 32'h0000FFFF);
      tick_to(p + 9);
      check("wrap_0000", 32'(step_count), 32'h00000000);
      tick_to(p + 13);
      check("wrap_0001", 32'(step_count), 32'h00000001);

      // Reset mid-divide.
      tick_to(p + 14);
      reset = 1'b1;
      tick_to(p + 15);
      check("midrst_step_count", 32'(step_count), 32'd0);
      check("midrst_cpu_en", 32'(cpu_en), 32'd0);
      tick_to(p + 16);
      reset = 1'b0;
      exp_q.push_back(p + 16 + RUN_DIV);
      tick_to(p + 23);
      check("post_rst_pending", 32'(exp_q.size()), 32'd0);
      check("post_rst_step_count", 32'(step_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
